// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four selectable test patterns.
// Mode and foreground changes are staged in pending registers and take
// effect only at the frame boundary, so a frame never shows a mixed pattern.
module vga_pattern_gen #(
    parameter int unsigned CH_W        = 1,
    parameter int unsigned TICK_DIV    = 2,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned CHECK_SHIFT = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [3*CH_W-1:0] fg_color,
    input  logic              mode_load,
    output logic              h_sync,
    output logic              v_sync,
    output logic [3*CH_W-1:0] RGB,
    output logic              video_on,
    output logic [9:0]        pixel_x,
    output logic [9:0]        pixel_y,
    output logic              frame_start
);

    localparam int unsigned RGB_W   = 3 * CH_W;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_CW    = $clog2(H_TOTAL);
    localparam int unsigned V_CW    = $clog2(V_TOTAL);
    localparam int unsigned DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned BAR_LEN = 1 << CHECK_SHIFT;

    logic [DIV_W-1:0] div_q;
    logic [H_CW-1:0]  h_q;
    logic [V_CW-1:0]  v_q;
    logic [H_CW-1:0]  bar_pos_q;
    logic [1:0]       act_mode_q;
    logic [1:0]       pend_mode_q;
    logic [RGB_W-1:0] act_fg_q;
    logic [RGB_W-1:0] pend_fg_q;

    logic             tick_c;
    logic             h_end_c;
    logic             v_end_c;
    logic             wrap_c;
    logic             active_c;
    logic             hs_c;
    logic             vs_c;
    logic             bar_hit_c;
    logic [2:0]       bar_idx_c;
    logic [2:0]       colour_c;
    logic [RGB_W-1:0] pixel_c;

    // Tick and end-of-line / end-of-frame decode
    always_comb begin
        tick_c  = (div_q == DIV_W'(TICK_DIV - 1));
        h_end_c = (h_q == H_CW'(H_TOTAL - 1));
        v_end_c = (v_q == V_CW'(V_TOTAL - 1));
        wrap_c  = tick_c && h_end_c && v_end_c;
    end

    // Divider, raster counters, bar position and staged mode registers
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            h_q         <= '0;
            v_q         <= '0;
            bar_pos_q   <= '0;
            act_mode_q  <= '0;
            pend_mode_q <= '0;
            act_fg_q    <= '0;
            pend_fg_q   <= '0;
        end else begin
            div_q <= tick_c ? '0 : div_q + DIV_W'(1);
            if (tick_c) begin
                h_q <= h_end_c ? '0 : h_q + H_CW'(1);
                if (h_end_c) begin
                    v_q <= v_end_c ? '0 : v_q + V_CW'(1);
                end
            end
            if (wrap_c) begin
                act_mode_q <= pend_mode_q;
                act_fg_q   <= pend_fg_q;
                bar_pos_q  <= (bar_pos_q == H_CW'(H_ACTIVE - 1)) ? '0 : bar_pos_q + H_CW'(1);
            end
            // A load on the wrap clock lands here after active took the old value
            if (mode_load) begin
                pend_mode_q <= mode;
                pend_fg_q   <= fg_color;
            end
        end
    end

    // Sync/blanking decode and pattern colour for the current raster position
    always_comb begin
        active_c  = (h_q < H_CW'(H_ACTIVE)) && (v_q < V_CW'(V_ACTIVE));
        hs_c      = !((h_q >= H_CW'(H_ACTIVE + H_FP)) &&
                      (h_q <= H_CW'(H_ACTIVE + H_FP + H_SYNC - 1)));
        vs_c      = !((v_q >= V_CW'(V_ACTIVE + V_FP)) &&
                      (v_q <= V_CW'(V_ACTIVE + V_FP + V_SYNC - 1)));
        bar_idx_c = 3'(h_q / H_CW'(BAR_W));
        colour_c  = ~bar_idx_c;
        bar_hit_c = ({1'b0, h_q} >= {1'b0, bar_pos_q}) &&
                    ({1'b0, h_q} < ({1'b0, bar_pos_q} + (H_CW + 1)'(BAR_LEN)));
        pixel_c   = '0;
        case (act_mode_q)
            2'd0: pixel_c = act_fg_q;
            2'd1: pixel_c = {{CH_W{colour_c[2]}}, {CH_W{colour_c[1]}}, {CH_W{colour_c[0]}}};
            2'd2: pixel_c = (h_q[CHECK_SHIFT] ^ v_q[CHECK_SHIFT]) ? '0 : act_fg_q;
            default: pixel_c = bar_hit_c ? act_fg_q : '0;
        endcase
        if (!active_c) begin
            pixel_c = '0;
        end
    end

    // Output register stage: every output lags counter state by one clk
    always_ff @(posedge clk) begin
        if (reset) begin
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
            RGB         <= '0;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
        end else begin
            h_sync      <= hs_c;
            v_sync      <= vs_c;
            RGB         <= pixel_c;
            video_on    <= active_c;
            pixel_x     <= 10'(h_q);
            pixel_y     <= 10'(v_q);
            frame_start <= (h_q == '0) && (v_q == '0) && (div_q == '0);
        end
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter CH_W, default 1, bits per colour channel; RGB is 3*CH_W wide, ordered {R,G,B}.
REQ-002 SHALL have parameter TICK_DIV, default 2, clk cycles per pixel tick (TICK_DIV >= 1).
REQ-003 SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in pixels.
REQ-004 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-005 SHALL have parameter CHECK_SHIFT, default 5, log2 of the checker square size and moving-bar width.
REQ-006 SHALL have clk, input, 1 bit, the single clock; reset is synchronous and active-high.
REQ-007 SHALL have reset, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have mode, input, 2 bits, requested pattern: 0 solid, 1 colour bars, 2 checkerboard, 3 moving bar.
REQ-009 SHALL have fg_color, input, 3*CH_W bits, requested foreground colour.
REQ-010 SHALL have mode_load, input, 1 bit, strobe capturing mode and fg_color into the pending registers.
REQ-011 SHALL have h_sync and v_sync, outputs, 1 bit each, active-low syncs.
REQ-012 SHALL have RGB, output, 3*CH_W bits, pixel colour, forced to 0 outside the active area.
REQ-013 SHALL have video_on, output, 1 bit, high inside the active area.
REQ-014 SHALL have pixel_x and pixel_y, outputs, 10 bits each, coordinates aligned with RGB.
REQ-015 SHALL have frame_start, output, 1 bit, one-clk pulse aligned with pixel (0,0).

Function
REQ-016 SHALL assert the internal tick for one clk every TICK_DIV clks; the divider counts 0..TICK_DIV-1.
REQ-017 SHALL advance the h counter on each tick, wrapping from H_TOTAL-1 (sum of H params, 800 by default) to 0; the v counter SHALL advance on that wrap, wrapping at V_TOTAL-1 (525 by default).
REQ-018 SHALL drive h_sync low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] and v_sync low for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-019 SHALL drive video_on high when h < H_ACTIVE and v < V_ACTIVE.
REQ-020 SHALL register every output: outputs in clk n+1 reflect counter state in clk n (latency 1 clk), with all outputs mutually aligned.
REQ-021 Mode 0: RGB = active fg.
REQ-022 Mode 1: eight bars, each H_ACTIVE/8 px wide; bar i = x/(H_ACTIVE/8); colour index c = 7-i; each channel is all-ones if its bit of c is set (bit2 R, bit1 G, bit0 B), else 0.
REQ-023 Mode 2: RGB = fg when x[CHECK_SHIFT] XOR y[CHECK_SHIFT] = 0, else 0.
REQ-024 Mode 3: RGB = fg when bar_pos <= x < bar_pos + 2^CHECK_SHIFT (no wrap of the bar body), else 0; bar_pos increments by 1 at each frame start, wrapping from H_ACTIVE-1 to 0.
REQ-025 mode_load SHALL overwrite the pending registers; with several loads in a frame, the last one wins.
REQ-026 Active mode/fg SHALL update from the pending registers only on the tick where counters wrap to (0,0); a mode_load in that same clk lands in pending and applies at the following frame.
REQ-027 frame_start SHALL pulse exactly once per V_TOTAL*H_TOTAL ticks.

Reset
REQ-028 Reset SHALL clear the divider, h, v, bar_pos, active and pending mode/fg to 0; RGB, video_on, pixel_x, pixel_y and frame_start to 0; h_sync and v_sync to 1.
REQ-029 Reset SHALL take priority over every other event, including mid-frame and mid-tick; counting SHALL resume from (0,0) in the clk after reset deasserts, with the first frame_start one clk later.

Verification
REQ-030 Defaults, reset held 5 clks then released -> h_sync=v_sync=1 and RGB=0 during reset; frame_start at clk 2 after release, then every 840000 clks.
REQ-031 Timing -> h_sync low for 192 clks starting at h=656; period 1600 clks; v_sync low during lines 490-491; video_on high for 1280 clks per active line.
REQ-032 Mode 1 loaded before a frame -> x=0 RGB=111, x=80 RGB=110, x=560 RGB=000, x=639 RGB=000; h=640 RGB=0.
REQ-033 Mode 2, fg=101 -> (0,0)=101, (32,0)=000, (32,32)=101, (0,479)=101.
REQ-034 Mode 0 with fg=010 loaded at (100,200) -> current frame keeps the old colour; the next frame shows 010 from (0,0); a load coincident with frame_start applies one frame later.
REQ-035 Mode 3, fg=111 -> frame k bar covers x=k..k+31; after 640 frames bar_pos=0; reset asserted mid-frame sets bar_pos=0 and counters to (0,0).
